// File: rtl/tia_l_cell_if.sv
// Data/control bundle for the TIA "L" latch cell.
// The master drives data and follow/latch controls; the cell returns out.
interface tia_l_cell_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic             follow;
    logic             latch;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        output follow,
        output latch,
        input  out
    );

    modport slave (
        input  in,
        input  follow,
        input  latch,
        output out
    );
endinterface

// File: rtl/tia_l_cell.sv
// Synchronous stand-in for the TIA "L" latch: a register plus an output mux.
// Transparent while follow is high, otherwise presents the stored bits.
module tia_l_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    tia_l_cell_if.slave  bus
);

    logic [WIDTH-1:0] store_q;
    logic [WIDTH-1:0] store_d;

    // latch only documents the hold phase; holding is the default behaviour
    logic unused_latch;
    assign unused_latch = bus.latch;

    // Capture on follow (follow wins over latch), otherwise hold.
    always_comb begin
        store_d = store_q;
        if (bus.follow) begin
            store_d = bus.in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_q <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    // Zero-latency output mux: reset forces 0, follow passes in through.
    always_comb begin
        bus.out = '0;
        if (!reset) begin
            bus.out = bus.follow ? bus.in : store_q;
        end
    end

endmodule

// File: tb/tb_tia_l_cell.sv
// Directed and randomized checks of tia_l_cell (WIDTH=8) against a
// behavioural model of the stored value and the output selection rules.
module tb_tia_l_cell;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [WIDTH-1:0] mdl_store;

    tia_l_cell_if #(.WIDTH(WIDTH)) bus ();

    tia_l_cell #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output from the current inputs and the modelled stored value.
    function automatic logic [WIDTH-1:0] expected_out();
        if (reset)           return '0;
        else if (bus.follow) return bus.in;
        else                 return mdl_store;
    endfunction

    task automatic check(input string tag);
        logic [WIDTH-1:0] exp_v;
        exp_v = expected_out();
        tests++;
        assert (bus.out === exp_v)
        else begin
            fails++;
            $error("FAIL %s: out=%h expected=%h", tag, bus.out, exp_v);
        end
    endtask

    // Also checks the model against an explicitly stated value.
    task automatic check_val(input string tag, input logic [WIDTH-1:0] want);
        tests++;
        assert (bus.out === want)
        else begin
            fails++;
            $error("FAIL %s: out=%h expected=%h", tag, bus.out, want);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic l,
                         input logic [WIDTH-1:0] d, input string tag);
        reset      = r;
        bus.follow = f;
        bus.latch  = l;
        bus.in     = d;
        #1;
        check(tag);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset)           mdl_store = '0;
        else if (bus.follow) mdl_store = bus.in;
        #1;
        check(tag);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        mdl_store = '0;
        reset      = 1'b1;
        bus.follow = 1'b1;
        bus.latch  = 1'b0;
        bus.in     = 8'hFF;

        // 1. reset forces out low even while transparent
        drive(1'b1, 1'b1, 1'b0, 8'hFF, "reset_comb");
        check_val("reset_zero", 8'h00);
        tick("reset_edge1");
        tick("reset_edge2");
        check_val("reset_zero_after", 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'hFF, "post_reset_hold");
        check_val("post_reset_zero", 8'h00);

        // 2. zero-cycle transparency
        drive(1'b0, 1'b1, 1'b0, 8'h00, "transp_0");
        drive(1'b0, 1'b1, 1'b0, 8'hFF, "transp_1");
        check_val("transp_1_val", 8'hFF);
        drive(1'b0, 1'b1, 1'b0, 8'h00, "transp_0b");

        // 3. capture then hold, both polarities
        drive(1'b0, 1'b1, 1'b0, 8'hFF, "cap_ones");
        tick("cap_ones_edge");
        drive(1'b0, 1'b0, 1'b1, 8'h00, "hold_ones");
        for (int i = 0; i < 5; i++) tick("hold_ones_edge");
        check_val("hold_ones_val", 8'hFF);
        drive(1'b0, 1'b1, 1'b0, 8'h00, "cap_zeros");
        tick("cap_zeros_edge");
        drive(1'b0, 1'b0, 1'b1, 8'hFF, "hold_zeros");
        for (int i = 0; i < 5; i++) tick("hold_zeros_edge");
        check_val("hold_zeros_val", 8'h00);

        // 4. follow and latch together: follow wins
        drive(1'b0, 1'b1, 1'b1, 8'hFF, "both_cap");
        tick("both_edge");
        drive(1'b0, 1'b0, 1'b1, 8'h00, "both_hold");
        check_val("both_hold_val", 8'hFF);

        // 5. neither asserted: no decay
        drive(1'b0, 1'b0, 1'b0, 8'h00, "neither");
        for (int i = 0; i < 10; i++) tick("neither_edge");
        check_val("neither_val", 8'hFF);

        // 6. reset during hold, then multi-bit capture
        drive(1'b0, 1'b0, 1'b1, 8'h00, "rst_hold_pre");
        drive(1'b1, 1'b0, 1'b1, 8'h00, "rst_hold_assert");
        tick("rst_hold_edge");
        drive(1'b0, 1'b0, 1'b0, 8'hFF, "rst_hold_release");
        check_val("rst_hold_val", 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'hA5, "cap_a5");
        tick("cap_a5_edge");
        drive(1'b0, 1'b0, 1'b1, 8'h5A, "hold_a5");
        tick("hold_a5_edge");
        check_val("hold_a5_val", 8'hA5);

        // Randomized sequences, occasional reset
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                  WIDTH'($urandom), "rand_comb");
            tick("rand_edge");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
